// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: sends a 6-byte UART message built from three ASCII
// digits: tens, ones, space, rev, CR, LF.
//
// Build option: define TX_PARITY_EN for 8E1 frames (even parity bit
// between the data bits and the stop bit). Default build is 8N1.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high reset
//   send     start request, only honoured while idle
//   tens_in  ASCII seconds-tens digit (7 bits)
//   ones_in  ASCII seconds-ones digit (7 bits)
//   rev_in   ASCII revolution digit (7 bits)
//   tx       serial line, idle high
//   busy     high while a message is being sent
//   done     one-cycle pulse as the message completes
module ascii_uart_tx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [6:0] tens_in,
    input  logic [6:0] ones_in,
    input  logic [6:0] rev_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [6:0]    tens_q;
    logic [6:0]    ones_q;
    logic [6:0]    rev_q;
    logic [7:0]    cur_byte;
    logic [2:0]    nxt_bit;
    logic          bit_end;

    // Byte currently on the wire; bit 7 is always zero.
    always_comb begin
        cur_byte = 8'h0A;
        unique case (byte_idx)
            3'd0:    cur_byte = {1'b0, tens_q};
            3'd1:    cur_byte = {1'b0, ones_q};
            3'd2:    cur_byte = 8'h20;
            3'd3:    cur_byte = {1'b0, rev_q};
            3'd4:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign bit_end = (timer == LAST);
    assign nxt_bit = bit_idx + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            timer    <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            tens_q   <= 7'h00;
            ones_q   <= 7'h00;
            rev_q    <= 7'h00;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    timer <= '0;
                    if (send) begin
                        tens_q   <= tens_in;
                        ones_q   <= ones_in;
                        rev_q    <= rev_in;
                        byte_idx <= 3'd0;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= 3'd0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                            tx    <= ^cur_byte;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= nxt_bit;
                            tx      <= cur_byte[nxt_bit];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        timer <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (byte_idx != 3'd5) begin
                            // Next byte starts with no idle gap.
                            byte_idx <= byte_idx + 3'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
